order_function_decoder: RTL
===========================

Name: order_function_decoder

Overview:
- Serial-to-parallel front end of the control section: receives each 17-bit short order from the order tank serially, LSB first, one digit per digit strobe.
- At end of the order it latches the 5-bit function code and drives exactly one of 32 one-hot order lines (the op_* set consumed by the order coder), plus the address field and the long/short flag.
- The op lines hold steady until the next complete order or a clear.

Parameters:
- ADDR_WIDTH, 10, width of address field; order width fixed at ADDR_WIDTH+7 (17 by default).
- FUNC_WIDTH, 5, function code width; fixed at 5, listed for documentation only.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- mc_start  input  1  qualifies the strobe carrying digit d0 of a new order
- digit_strobe  input  1  one serial digit present on ord_bit this cycle
- ord_bit  input  1  serial order digit, LSB (d0) first
- clear_order  input  1  forces op lines to all-zero (starter / stop)
- op_onehot  output  32  bit i high means function code i (table below)
- order_addr  output  ADDR_WIDTH  latched address field
- order_long  output  1  latched L digit (1 = long operand)
- order_valid  output  1  one-cycle pulse when new outputs are latched
- frame_err  output  1  one-cycle pulse on truncated order

Behaviour:
- Digit layout:
  - d0 = L.
  - d1..d10 = address, d1 is the LSB.
  - d11 = spare, ignored.
  - d12..d16 = function code, d12 is the LSB.
- Code map, 0..31: P Q W E R T Y U I O J pi S Z K erase blank F theta D phi H N M delta L X G A B C V.
  - Example: A=28, S=12, T=5, P=0.
- States:
  - IDLE: waiting for an order.
  - SHIFT: accepting digits. A 5-bit digit counter cnt counts 0..16. Shift register is 17 bits.
- IDLE:
  - A strobe with mc_start shifts in d0, sets cnt=1 and moves to SHIFT.
  - A strobe without mc_start is ignored.
- SHIFT:
  - Each strobe without mc_start shifts in one digit and increments cnt.
  - Cycles with no strobe hold all state; no timeout.
- Completion: on the strobe for d16 (cnt=16):
  - Next cycle, op_onehot = 1 << code and order_addr/order_long are updated.
  - order_valid pulses high for exactly 1 cycle.
  - FSM returns to IDLE the same cycle.
  - Latency is one clock from the d16 strobe edge to the outputs.
- Back-to-back orders: the d0 strobe of the next order may occur in the cycle immediately after d16. It is accepted normally.
- mc_start with a strobe while in SHIFT (before d16):
  - The partial order is discarded.
  - frame_err pulses for 1 cycle.
  - The digit is taken as d0 of a new order (cnt=1, stays in SHIFT).
  - Latched outputs are unchanged.
- mc_start without digit_strobe is ignored.
- clear_order:
  - The next cycle op_onehot = 0. order_addr and order_long are retained.
  - Does not disturb shifting.
  - If it coincides with a completing d16 strobe, clear wins: op_onehot = 0, order_valid stays low, addr/long still update.
- op_onehot is either all-zero or exactly one bit set; never two bits.
- Reset (any time, including mid-order):
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - The shift register and counter are cleared.
  - The partial order is lost and no frame_err is raised.

Test Plan:
- Reset, then serial "A 5 S" (L=0, addr=5, code 28; digits d0..d16 = 0,1,0,1,0,0,0,0,0,0,0,0,0,0,1,1,1) on consecutive strobes -> 1 cycle after the d16 strobe: op_onehot=0x1000_0000, order_addr=5, order_long=0, order_valid high for exactly 1 cycle.
- "P 0 L" (all digits 0 except d0=1), strobes every 3rd cycle -> op_onehot=0x0000_0001, order_addr=0, order_long=1. Outputs stable until the next order completes.
- Two back-to-back orders, "T 1023 S" then "V 0 S" (codes 5, 31), with mc_start directly after d16 -> two order_valid pulses 17 strobes apart, op_onehot 0x20 then 0x8000_0000.
- mc_start+strobe at digit 9 of an order -> frame_err 1-cycle pulse, prior outputs unchanged. The following 16 strobes complete the new order correctly.
- clear_order asserted on the d16 strobe cycle of "E 7 S" -> op_onehot=0, order_valid low, order_addr=7.
- rst asserted at digit 8, then released, then a full "A 5 S" order -> outputs 0 after reset, no frame_err, the order decodes correctly.

Source files
------------

// File: rtl/order_function_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : order_function_decoder
//  Description : Serial-to-parallel order front end. Collects a short order
//                LSB first, one digit per strobe. At the end of the order it
//                latches the address, the long/short digit and a one-hot
//                function line for the order coder.
//  Revision    : 1.0 - initial release
// ============================================================================
module order_function_decoder #(
    parameter int ADDR_WIDTH = 10,
    parameter int FUNC_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mc_start,
    input  logic                  digit_strobe,
    input  logic                  ord_bit,
    input  logic                  clear_order,
    output logic [31:0]           op_onehot,
    output logic [ADDR_WIDTH-1:0] order_addr,
    output logic                  order_long,
    output logic                  order_valid,
    output logic                  frame_err
);

    // Order layout: L digit, address, one spare digit, function code.
    localparam int c_order_w  = ADDR_WIDTH + 2 + FUNC_WIDTH;
    localparam int c_cnt_w    = $clog2(c_order_w);
    localparam int c_func_lsb = ADDR_WIDTH + 2;

    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_order_w - 1);
    localparam logic [c_cnt_w-1:0] c_one_cnt  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q,       state_d;
    logic [c_cnt_w-1:0]     cnt_q,         cnt_d;
    logic [c_order_w-1:0]   sreg_q,        sreg_d;
    logic [31:0]            op_onehot_q,   op_onehot_d;
    logic [ADDR_WIDTH-1:0]  order_addr_q,  order_addr_d;
    logic                   order_long_q,  order_long_d;
    logic                   order_valid_q, order_valid_d;
    logic                   frame_err_q,   frame_err_d;

    // The register with the current digit shifted in at the top. After the
    // final digit this is the complete order with d0 at bit 0.
    logic [c_order_w-1:0]   w_shifted;
    logic [FUNC_WIDTH-1:0]  w_code;

    assign w_shifted = {ord_bit, sreg_q[c_order_w-1:1]};
    assign w_code    = w_shifted[c_func_lsb +: FUNC_WIDTH];

    // Next-state: digit collection, restart on mc_start, latch at completion.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sreg_d        = sreg_q;
        op_onehot_d   = op_onehot_q;
        order_addr_d  = order_addr_q;
        order_long_d  = order_long_q;
        order_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        if (digit_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    // Only a strobe qualified by mc_start can open an order.
                    if (mc_start) begin
                        sreg_d  = w_shifted;
                        cnt_d   = c_one_cnt;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (mc_start) begin
                        // Truncated order: drop it and treat this digit as
                        // d0 of a fresh one. Stale digits are shifted out
                        // before the new order completes.
                        frame_err_d = 1'b1;
                        sreg_d      = w_shifted;
                        cnt_d       = c_one_cnt;
                    end else if (cnt_q == c_last_cnt) begin
                        sreg_d        = w_shifted;
                        cnt_d         = '0;
                        state_d       = ST_IDLE;
                        order_addr_d  = w_shifted[ADDR_WIDTH:1];
                        order_long_d  = w_shifted[0];
                        op_onehot_d   = '0;
                        op_onehot_d[w_code] = 1'b1;
                        order_valid_d = 1'b1;
                    end else begin
                        sreg_d = w_shifted;
                        cnt_d  = cnt_q + c_one_cnt;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Clear overrides any completing order on the op lines only; the
        // address and L digit still take the new values.
        if (clear_order) begin
            op_onehot_d   = '0;
            order_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sreg_q        <= '0;
            op_onehot_q   <= '0;
            order_addr_q  <= '0;
            order_long_q  <= 1'b0;
            order_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sreg_q        <= sreg_d;
            op_onehot_q   <= op_onehot_d;
            order_addr_q  <= order_addr_d;
            order_long_q  <= order_long_d;
            order_valid_q <= order_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign op_onehot   = op_onehot_q;
    assign order_addr  = order_addr_q;
    assign order_long  = order_long_q;
    assign order_valid = order_valid_q;
    assign frame_err   = frame_err_q;

endmodule
`default_nettype wire
